streamlined_mul_add_8bit: RTL and testbench



---
 rtl/streamlined_mul_add_8bit.sv | 143 ++++++++++++++
 tb/tb_streamlined_mul_add_8bit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/streamlined_mul_add_8bit.sv
// Sequential signed 8x8 shift-add multiplier with optional signed addend (16-bit result).
// Define MULADD_ADDEND_EN to latch the addend at start and add it at completion.
`timescale 1ns/1ps

module streamlined_mul_add_8bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_sig,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  input  logic [7:0]  addend,
  output logic        busy_sig,
  output logic        done_sig,
  output logic [15:0] product,
  output logic [1:0]  dbg_state_o
);

  // Handshake: start_sig is sampled only while idle; busy_sig is high from the
  // cycle after acceptance until done_sig, which pulses for exactly one cycle
  // alongside the new product value. Requests while busy are dropped.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  a_mag_q, a_mag_d;
  logic [7:0]  b_mag_q, b_mag_d;
  logic        neg_q, neg_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] prod_q, prod_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [7:0]  a_abs;
  logic [7:0]  b_abs;
  logic [15:0] partial;
  logic [15:0] signed_acc;
  logic [15:0] c_ext;

  // Negating 0x80 in 8 bits yields 0x80, which read as unsigned is the correct 128.
  assign a_abs      = multiplicand[7] ? 8'(-multiplicand) : multiplicand;
  assign b_abs      = multiplier[7]   ? 8'(-multiplier)   : multiplier;
  assign partial    = {8'd0, a_mag_q} << cnt_q;
  assign signed_acc = neg_q ? (16'd0 - acc_q) : acc_q;

`ifdef MULADD_ADDEND_EN
  logic [15:0] c_q, c_d;
  assign c_ext = c_q;
`else
  logic unused_addend;
  assign unused_addend = ^addend;
  assign c_ext = 16'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef MULADD_ADDEND_EN
    c_d     = c_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_sig) begin
          a_mag_d = a_abs;
          b_mag_d = b_abs;
          neg_d   = multiplicand[7] ^ multiplier[7];
          acc_d   = 16'd0;
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = S_ITER;
`ifdef MULADD_ADDEND_EN
          c_d     = {{8{addend[7]}}, addend};
`endif
        end
      end
      S_ITER: begin
        if (b_mag_q[cnt_q]) begin
          acc_d = acc_q + partial;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Magnitude fits in 15 bits, so the sign fix-up plus addend never overflows.
        prod_d  = signed_acc + c_ext;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      a_mag_q <= 8'd0;
      b_mag_q <= 8'd0;
      neg_q   <= 1'b0;
      acc_q   <= 16'd0;
      prod_q  <= 16'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MULADD_ADDEND_EN
      c_q     <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef MULADD_ADDEND_EN
      c_q     <= c_d;
`endif
    end
  end

  assign busy_sig    = busy_q;
  assign done_sig    = done_q;
  assign product     = prod_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_streamlined_mul_add_8bit.sv
// Bench for streamlined_mul_add_8bit: directed vectors, arithmetic reference model
// with a per-cycle compare, and literal expectations for the documented cases.
`timescale 1ns/1ps

module tb_streamlined_mul_add_8bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_sig;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [7:0]  addend;
  logic        busy_sig;
  logic        done_sig;
  logic [15:0] product;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  streamlined_mul_add_8bit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_sig    (start_sig),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy_sig     (busy_sig),
    .done_sig     (done_sig),
    .product      (product),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_result(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c);
    int p;
    logic [7:0] c_eff;
`ifdef MULADD_ADDEND_EN
    c_eff = c;
`else
    c_eff = 8'd0;
`endif
    p = int'($signed(a)) * int'($signed(b)) + int'($signed(c_eff));
    return p[15:0];
  endfunction

  logic [15:0] exp_q[$];
  int          m_cnt;
  logic [15:0] m_prod;
  logic        m_done;

  // Cycle-count view: an accepted op completes 9 edges later; requests while busy vanish.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_prod = 16'h0000;
      m_done = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (start_sig) begin
          m_cnt = 9;
          exp_q.push_back(model_result(multiplicand, multiplier, addend));
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_prod = exp_q.pop_front();
          m_done = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check1("cycle done_sig", done_sig, m_done);
      check1("cycle busy_sig", busy_sig, (m_cnt != 0));
      check16("cycle product", product, m_prod);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    start_sig    = 1'b1;
  endtask

  // Called on a negedge; counts negedges until done_sig shows, bounded.
  task automatic wait_done(input string name, input int exp_cyc);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_sig && cyc < 30);
    n_vec++;
    if (!done_sig || cyc != exp_cyc) begin
      n_err++;
      $display("FAIL %s latency: done_sig=%b after %0d cycles, expected 1 after %0d",
               name, done_sig, cyc, exp_cyc);
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [15:0] exp);
    @(negedge clk);
    drive_start(a, b, c);
    @(negedge clk);
    start_sig    = 1'b0;
    multiplicand = 8'h55;
    multiplier   = 8'hAA;
    addend       = 8'h7F;
    wait_done(name, 9);
    check16(name, product, exp);
  endtask

`ifdef MULADD_ADDEND_EN
  localparam logic [15:0] EXP_M4X6P5  = 16'hFFED;
  localparam logic [15:0] EXP_18XM7P6 = 16'hFF88;
`else
  localparam logic [15:0] EXP_M4X6P5  = 16'hFFE8;
  localparam logic [15:0] EXP_18XM7P6 = 16'hFF82;
`endif

  // ---------------- main sequence ----------------
  initial begin
    rst_n        = 1'b0;
    start_sig    = 1'b0;
    multiplicand = 8'h00;
    multiplier   = 8'h00;
    addend       = 8'h00;

    // Pin the model against hand-computed values.
    check16("model 7x-3",      model_result(8'h07, 8'hFD, 8'h00), 16'hFFEB);
    check16("model -128x-128", model_result(8'h80, 8'h80, 8'h00), 16'h4000);
    check16("model -4x6+5",    model_result(8'hFC, 8'h06, 8'h05), EXP_M4X6P5);
    check16("model 127x127",   model_result(8'h7F, 8'h7F, 8'h00), 16'h3F01);

    repeat (2) @(negedge clk);
    check16("reset product", product, 16'h0000);
    check1("reset done_sig", done_sig, 1'b0);
    check1("reset busy_sig", busy_sig, 1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("7x-3",      8'h07, 8'hFD, 8'h00, 16'hFFEB);
    run_op("-128x-128", 8'h80, 8'h80, 8'h00, 16'h4000);
    run_op("-128x127",  8'h80, 8'h7F, 8'h00, 16'hC080);
    run_op("-4x6+5",    8'hFC, 8'h06, 8'h05, EXP_M4X6P5);
    run_op("18x-7+6",   8'h12, 8'hF9, 8'h06, EXP_18XM7P6);

    // Start pulse at E4 of an in-flight op must be ignored.
    @(negedge clk);
    drive_start(8'h00, 8'hFF, 8'h00);
    @(negedge clk);
    start_sig = 1'b0;
    repeat (3) @(negedge clk);
    drive_start(8'h05, 8'h05, 8'h03);
    @(negedge clk);
    start_sig = 1'b0;
    wait_done("0x-1 with busy start", 5);
    check16("0x-1", product, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check1("no extra done", done_sig, 1'b0);
    end
    check16("0x-1 held", product, 16'h0000);

    // Reset mid-operation.
    run_op("127x127", 8'h7F, 8'h7F, 8'h00, 16'h3F01);
    @(negedge clk);
    drive_start(8'hFD, 8'h07, 8'h00);
    @(negedge clk);
    start_sig = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check16("abort product", product, 16'h0000);
    check1("abort busy_sig", busy_sig, 1'b0);
    check1("abort done_sig", done_sig, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check1("abort no done", done_sig, 1'b0);
    end
    rst_n = 1'b1;
    run_op("-5x5 after reset", 8'hFB, 8'h05, 8'h00, 16'hFFE7);

    // start_sig held high: three back-to-back ops.
    @(negedge clk);
    drive_start(8'h02, 8'h03, 8'h00);
    @(negedge clk);
    multiplicand = 8'hFB;
    multiplier   = 8'h05;
    wait_done("b2b op1", 9);
    check16("b2b 2x3", product, 16'h0006);
    @(negedge clk);
    multiplicand = 8'h7F;
    multiplier   = 8'h7F;
    wait_done("b2b op2", 9);
    check16("b2b -5x5", product, 16'hFFE7);
    @(negedge clk);
    start_sig = 1'b0;
    wait_done("b2b op3", 9);
    check16("b2b 127x127", product, 16'h3F01);

    repeat (12) @(negedge clk);
    check1("final idle", busy_sig, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
